// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Latency: request handshake at cycle t -> response valid at t+2; at least 3 cycles per operation.
// Backpressure: one operation in flight; no new request is accepted until the owner takes its result.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_res,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic             grant0, grant1;
  logic             owner_resp_ready;

  // Round-robin grant in IDLE: a lone requester wins, a tie goes to whoever was not served last
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  // Next-state logic: capture operands at handshake, latch ALU result in EXEC, release on owner's ready
  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    result_d     = result_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    owner_resp_ready = owner_q ? resp1_ready : resp0_ready;
    case (state_q)
      IDLE: begin
        if (grant0) begin
          alu_a_d  = req0_a;
          alu_b_d  = req0_b;
          alu_op_d = req0_op;
          owner_d  = 1'b0;
          state_d  = EXEC;
        end else if (grant1) begin
          alu_a_d  = req1_a;
          alu_b_d  = req1_b;
          alu_op_d = req1_op;
          owner_d  = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        result_d     = alu_res;
        last_grant_d = owner_q;
        state_d      = RESP;
      end
      RESP: begin
        if (owner_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      result_q     <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      result_q     <= result_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign resp0_valid = (state_q == RESP) && !owner_q;
  assign resp1_valid = (state_q == RESP) && owner_q;
  assign resp0_data  = result_q;
  assign resp1_data  = result_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, resp0_valid, resp0_ready;
  logic [31:0] req0_a, req0_b, resp0_data;
  logic [3:0]  req0_op;
  logic        req1_valid, req1_ready, resp1_valid, resp1_ready;
  logic [31:0] req1_a, req1_b, resp1_data;
  logic [3:0]  req1_op;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_op;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .OP_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res), .busy(busy)
  );

  // Stand-in ALU driven by the arbiter's registered operands
  always_comb begin
    case (alu_op)
      4'b0000: alu_res = alu_a + alu_b;
      4'b1000: alu_res = alu_a - alu_b;
      4'b0100: alu_res = alu_a ^ alu_b;
      4'b0010: alu_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'b0011: alu_res = (alu_a < alu_b) ? 32'd1 : 32'd0;
      4'b0110: alu_res = alu_a | alu_b;
      default: alu_res = 32'hDEADBEEF;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic drive_req(input logic who, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (who) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  // One uncontended operation; called at a negedge with the arbiter idle
  task automatic run_op(input logic who, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input string nm);
    drive_req(who, op, a, b);
    #1;
    chk({nm, " ready"}, who ? req1_ready : req0_ready, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk({nm, " exec busy"}, busy, 32'd1);
    chk({nm, " exec alu_a"}, alu_a, a);
    chk({nm, " exec alu_b"}, alu_b, b);
    chk({nm, " exec alu_op"}, alu_op, op);
    @(negedge clk);
    chk({nm, " resp valid"}, who ? resp1_valid : resp0_valid, 32'd1);
    chk({nm, " other valid"}, who ? resp0_valid : resp1_valid, 32'd0);
    chk({nm, " resp data"}, who ? resp1_data : resp0_data, exp);
    if (who) resp1_ready = 1'b1; else resp0_ready = 1'b1;
    @(negedge clk);
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    chk({nm, " idle"}, busy, 32'd0);
  endtask

  typedef struct {
    logic        who;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];
  int   seen_resp1;
  int   seen_ready1;

  initial begin
    vecs[0] = '{who: 1'b0, op: 4'b0000, a: 32'd5,          b: 32'd7,   exp: 32'd12};
    vecs[1] = '{who: 1'b0, op: 4'b1000, a: 32'd10,         b: 32'd3,   exp: 32'd7};
    vecs[2] = '{who: 1'b1, op: 4'b0100, a: 32'h000000F0,   b: 32'hFF,  exp: 32'h0000000F};
    vecs[3] = '{who: 1'b0, op: 4'b0010, a: 32'hFFFFFFFF,   b: 32'd1,   exp: 32'd1};
    vecs[4] = '{who: 1'b1, op: 4'b0011, a: 32'hFFFFFFFF,   b: 32'd1,   exp: 32'd0};
    vecs[5] = '{who: 1'b1, op: 4'b1111, a: 32'h12345678,   b: 32'd9,   exp: 32'hDEADBEEF};

    rst = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0; resp0_ready = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0; resp1_ready = 0;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset alu_a", alu_a, 0);
    chk("reset alu_op", alu_op, 0);
    chk("reset resp0_valid", resp0_valid, 0);
    chk("reset resp1_valid", resp1_valid, 0);
    chk("reset resp0_data", resp0_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table of uncontended operations, including signed/unsigned compare and an unknown op code
    for (int i = 0; i < 6; i++)
      run_op(vecs[i].who, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    // Contention: last served was req1, so req0 wins, then strict alternation
    drive_req(1'b0, 4'b1000, 32'd10, 32'd3);
    drive_req(1'b1, 4'b0100, 32'hF0, 32'hFF);
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    #1;
    chk("cont1 req0_ready", req0_ready, 1);
    chk("cont1 req1_ready", req1_ready, 0);
    @(negedge clk);
    chk("cont exec req0_ready", req0_ready, 0);
    chk("cont exec req1_ready", req1_ready, 0);
    @(negedge clk);
    chk("cont1 resp0_valid", resp0_valid, 1);
    chk("cont1 resp0_data", resp0_data, 7);
    chk("cont resp req1_ready", req1_ready, 0);
    @(negedge clk);
    chk("cont2 req1_ready", req1_ready, 1);
    chk("cont2 req0_ready", req0_ready, 0);
    @(negedge clk);
    drive_req(1'b0, 4'b0000, 32'd1, 32'd2);
    @(negedge clk);
    chk("cont2 resp1_valid", resp1_valid, 1);
    chk("cont2 resp1_data", resp1_data, 32'h0F);
    @(negedge clk);
    chk("cont3 req0_ready", req0_ready, 1);
    chk("cont3 req1_ready", req1_ready, 0);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk("cont3 resp0_data", resp0_data, 3);
    @(negedge clk);
    resp0_ready = 0; resp1_ready = 0;
    chk("cont idle", busy, 0);

    // Backpressure on requester 1 while requester 0 keeps asking
    drive_req(1'b1, 4'b0000, 32'd100, 32'd23);
    @(negedge clk);
    req1_valid = 0;
    drive_req(1'b0, 4'b0110, 32'hA0, 32'h0B);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d resp1_valid", c), resp1_valid, 1);
      chk($sformatf("bp%0d resp1_data", c), resp1_data, 123);
      chk($sformatf("bp%0d req0_ready", c), req0_ready, 0);
      @(negedge clk);
    end
    resp1_ready = 1'b1;
    @(negedge clk);
    resp1_ready = 1'b0;
    chk("bp release req0_ready", req0_ready, 1);
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    // Non-owner ready must not release the response
    resp1_ready = 1'b1;
    @(negedge clk);
    chk("nonowner busy", busy, 1);
    chk("nonowner resp0_valid", resp0_valid, 1);
    chk("nonowner resp0_data", resp0_data, 32'hAB);
    resp1_ready = 1'b0; resp0_ready = 1'b1;
    @(negedge clk);
    resp0_ready = 1'b0;
    chk("bp idle", busy, 0);

    // Reset during EXEC discards the operation and restores tie priority to req0
    drive_req(1'b1, 4'b1000, 32'd9, 32'd4);
    @(negedge clk);
    req1_valid = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid busy", busy, 0);
    chk("rstmid resp0_valid", resp0_valid, 0);
    chk("rstmid resp1_valid", resp1_valid, 0);
    chk("rstmid alu_op", alu_op, 0);
    chk("rstmid alu_a", alu_a, 0);
    drive_req(1'b0, 4'b0000, 32'd1, 32'd1);
    drive_req(1'b1, 4'b0000, 32'd2, 32'd2);
    #1;
    chk("rstmid req0_ready", req0_ready, 1);
    chk("rstmid req1_ready", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk("rstmid no handshake", busy, 0);

    // Requester 1 withdraws while requester 0 is served; it must never get a response
    seen_resp1 = 0;
    seen_ready1 = 0;
    drive_req(1'b0, 4'b0000, 32'd40, 32'd2);
    resp0_ready = 1'b1;
    @(negedge clk);
    req0_valid = 0;
    drive_req(1'b1, 4'b0000, 32'd7, 32'd7);
    for (int c = 0; c < 8; c++) begin
      if (resp1_valid) seen_resp1++;
      if (req1_ready) seen_ready1++;
      if (c == 0) begin
        @(negedge clk);
        chk("wd resp0_data", resp0_data, 42);
        if (resp1_valid) seen_resp1++;
        if (req1_ready) seen_ready1++;
        req1_valid = 0;
      end
      @(negedge clk);
    end
    resp0_ready = 1'b0;
    chk("wd resp1 count", seen_resp1, 0);
    chk("wd req1_ready count", seen_ready1, 0);
    chk("wd idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
